mul_hilo_ctrl: RTL and testbench

Sequencing and result-capture stage wrapped around the combinational radix-4 Booth multiplier in the Mini SRC datapath. It accepts a multiply request from the control unit and latches both operands onto the multiplier inputs. It waits a programmable number of cycles for the 64-bit product to settle, then captures it into the architectural HI and LO registers. The stage also serves the mthi/mtlo writes and drives the mfhi/mflo read values.

---
 rtl/mul_hilo_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// mul_hilo_ctrl
//
// Sequencing and result-capture stage around the combinational Booth
// multiplier of the Mini SRC datapath. A multiply request latches both
// operands onto the multiplier inputs. The stage then lets the product
// settle for SETTLE_CYCLES full cycles plus one capture cycle, and finally
// writes the 64-bit product into the architectural HI/LO registers. The
// stage also serves mthi/mtlo writes, which are honoured only while idle.
//
// Parameters:
//   SETTLE_CYCLES  settle cycles before the capture cycle (legal 1..15)
//
// Ports:
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start_i    multiply request, accepted only while ready_o=1
//   op_a_i     signed multiplicand, sampled on acceptance
//   op_b_i     signed multiplier, sampled on acceptance
//   ready_o    high only in IDLE
//   busy_o     inverse of ready_o
//   mul_a_o    registered operand to multiplier input a
//   mul_b_o    registered operand to multiplier input b
//   mul_c_i    64-bit product from the multiplier
//   hi_we_i    mthi strobe
//   lo_we_i    mtlo strobe
//   wdata_i    data for mthi/mtlo
//   acc_i      accumulate select (present only with MULHILO_ACC_EN)
//   hi_o       HI register
//   lo_o       LO register
//   done_o     one-cycle pulse: HI/LO hold the new product
//
// Build option:
//   MULHILO_ACC_EN  when defined, adds acc_i. A request taken with acc_i=1
//                   makes the capture load {hi_o,lo_o} + mul_c_i (mod 2^64).
// ---------------------------------------------------------------------------
module mul_hilo_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [63:0] mul_c_i,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [31:0] wdata_i,
`ifdef MULHILO_ACC_EN
    input  logic        acc_i,
`endif
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        done_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    // The counter starts one below the settle count, so SETTLE lasts
    // exactly SETTLE_CYCLES cycles including the cycle where cnt reaches 0.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [63:0] capture_value;

    assign ready_o = (state == ST_IDLE);
    assign busy_o  = ~ready_o;

    // Sequencing: IDLE -> SETTLE (counted) -> CAPTURE -> IDLE. A request
    // arriving while busy is simply dropped, there is no queue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state <= ST_SETTLE;
                        cnt   <= CNT_INIT;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == 4'd0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand latches feed the multiplier and stay stable for the whole
    // settle window, which is what makes the multicycle constraint valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mul_a_o <= 32'd0;
            mul_b_o <= 32'd0;
        end else if (ready_o && start_i) begin
            mul_a_o <= op_a_i;
            mul_b_o <= op_b_i;
        end
    end

`ifdef MULHILO_ACC_EN
    logic acc_hold;

    // The accumulate choice belongs to the request, so it is frozen at
    // acceptance rather than read from acc_i at capture time.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_hold <= 1'b0;
        end else if (ready_o && start_i) begin
            acc_hold <= acc_i;
        end
    end

    assign capture_value = acc_hold ? ({hi_o, lo_o} + mul_c_i) : mul_c_i;
`else
    assign capture_value = mul_c_i;
`endif

    // HI/LO: the capture edge loads the product; mthi/mtlo writes land only
    // while idle. A write in the same cycle as an accepted request still
    // happens and is later overwritten by that request's capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_o <= 32'd0;
            lo_o <= 32'd0;
        end else if (state == ST_CAPTURE) begin
            hi_o <= capture_value[63:32];
            lo_o <= capture_value[31:0];
        end else if (ready_o) begin
            if (hi_we_i) begin
                hi_o <= wdata_i;
            end
            if (lo_we_i) begin
                lo_o <= wdata_i;
            end
        end
    end

    // done_o is high for the single cycle after the capture edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_o <= 1'b0;
        end else begin
            done_o <= (state == ST_CAPTURE);
        end
    end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_hilo_ctrl
//
// Self-checking bench for mul_hilo_ctrl. The multiplier is stood in for by a
// combinational signed product of mul_a_o/mul_b_o. Expected HI/LO values
// come from a plain 64-bit architectural model of HI:LO updated by the
// bench's own view of requests and writes. Accumulate cases are exercised
// when MULHILO_ACC_EN is defined.
// ---------------------------------------------------------------------------
module tb_mul_hilo_ctrl;

    localparam int S = 2;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        ready;
    logic        busy;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_c;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        acc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;

    int checks;
    int fails;

    // Architectural HI:LO as the bench expects it, and the value the
    // in-flight request is due to deliver.
    logic [63:0] model_hilo;
    logic [63:0] exp_hilo;

    mul_hilo_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start_i (start),
        .op_a_i  (op_a),
        .op_b_i  (op_b),
        .ready_o (ready),
        .busy_o  (busy),
        .mul_a_o (mul_a),
        .mul_b_o (mul_b),
        .mul_c_i (mul_c),
        .hi_we_i (hi_we),
        .lo_we_i (lo_we),
        .wdata_i (wdata),
`ifdef MULHILO_ACC_EN
        .acc_i   (acc),
`endif
        .hi_o    (hi),
        .lo_o    (lo),
        .done_o  (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the combinational Booth multiplier.
    always_comb begin
        mul_c = 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
    end

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present a request for one cycle and record what it should deliver.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic acc_sel);
        check_output("ready_before_start", 64'(ready), 64'd1);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        acc   = acc_sel;
`ifdef MULHILO_ACC_EN
        exp_hilo = acc_sel ? (model_hilo + ref_prod(a, b)) : ref_prod(a, b);
`else
        exp_hilo = ref_prod(a, b);
`endif
        step();
        start = 1'b0;
        acc   = 1'b0;
        check_output("busy_after_accept", 64'(busy), 64'd1);
        check_output("mul_a_latched", 64'(mul_a), 64'(a));
        check_output("mul_b_latched", 64'(mul_b), 64'(b));
    endtask

    // Wait (bounded) for done; skip is the number of edges already consumed.
    task automatic wait_done(input string tag, input int skip);
        int n;
        n = skip;
        while (done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check_output({tag, "_latency"}, 64'(n), 64'(S + 1));
        check_output({tag, "_hilo"}, {hi, lo}, exp_hilo);
        check_output({tag, "_ready_in_done"}, 64'(ready), 64'd1);
        model_hilo = exp_hilo;
    endtask

    initial begin
        int done_seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rw;
        logic        rsel;

        checks     = 0;
        fails      = 0;
        model_hilo = 64'd0;
        exp_hilo   = 64'd0;
        reset_n    = 1'b0;
        start      = 1'b0;
        op_a       = 32'd0;
        op_b       = 32'd0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        wdata      = 32'd0;
        acc        = 1'b0;

        // Reset state
        repeat (2) step();
        check_output("rst_ready", 64'(ready), 64'd1);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_hilo", {hi, lo}, 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // 7 * -3
        apply_stimulus(32'd7, 32'hFFFF_FFFD, 1'b0);
        wait_done("mul_7_m3", 0);
        check_output("mul_7_m3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        step();
        check_output("mul_7_m3_done_clears", 64'(done), 64'd0);

        // Most-negative squared, then back-to-back -1 * -1 from the done cycle
        apply_stimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done("mul_min_sq", 0);
        check_output("mul_min_sq_const", {hi, lo}, 64'h4000_0000_0000_0000);
        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_output("b2b_done_clears", 64'(done), 64'd0);
        wait_done("mul_m1_sq", 0);
        check_output("mul_m1_sq_const", {hi, lo}, 64'h0000_0000_0000_0001);
        step();

        // Start and writes while busy are ignored
        apply_stimulus(32'h0001_2345, 32'hFFFE_0001, 1'b0);
        start = 1'b1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        op_a  = 32'h1111_1111;
        op_b  = 32'h2222_2222;
        step();
        step();
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wait_done("busy_ignore", 2);
        check_output("busy_ignore_mul_a", 64'(mul_a), 64'h0001_2345);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1) done_seen++;
        end
        check_output("busy_ignore_no_second_done", 64'(done_seen), 64'd0);
        check_output("busy_ignore_hilo_kept", {hi, lo}, model_hilo);

        // Reset asserted during CAPTURE
        apply_stimulus(32'h1234_5678, 32'h0000_0100, 1'b0);
        step();
        step();
        check_output("capture_busy", 64'(busy), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("midrst_hilo", {hi, lo}, 64'd0);
        check_output("midrst_ready", 64'(ready), 64'd1);
        check_output("midrst_done", 64'(done), 64'd0);
        model_hilo = 64'd0;
        done_seen  = 0;
        step();
        if (done === 1'b1) done_seen++;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done === 1'b1) done_seen++;
        end
        check_output("midrst_no_done", 64'(done_seen), 64'd0);
        check_output("midrst_hilo_after", {hi, lo}, 64'd0);

        // mthi / mtlo in IDLE
        hi_we = 1'b1;
        wdata = 32'h1234_5678;
        step();
        hi_we = 1'b0;
        model_hilo[63:32] = 32'h1234_5678;
        check_output("mthi", {hi, lo}, model_hilo);
        lo_we = 1'b1;
        wdata = 32'h9ABC_DEF0;
        step();
        lo_we = 1'b0;
        model_hilo[31:0] = 32'h9ABC_DEF0;
        check_output("mtlo", {hi, lo}, model_hilo);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hA5A5_0F0F;
        step();
        hi_we = 1'b0;
        lo_we = 1'b0;
        model_hilo = {32'hA5A5_0F0F, 32'hA5A5_0F0F};
        check_output("mthi_mtlo_both", {hi, lo}, model_hilo);

        // Write and request in the same IDLE cycle
        hi_we = 1'b1;
        wdata = 32'h0BAD_F00D;
        model_hilo[63:32] = 32'h0BAD_F00D;
        apply_stimulus(32'hFFFF_FF00, 32'h0000_0010, 1'b0);
        hi_we = 1'b0;
        check_output("same_cycle_write", 64'(hi), 64'h0BAD_F00D);
        wait_done("same_cycle_mul", 0);
        step();

`ifdef MULHILO_ACC_EN
        // Accumulate: 0:FFFFFFFF + 1*1 carries into HI
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_0000;
        step();
        hi_we = 1'b0;
        wdata = 32'hFFFF_FFFF;
        step();
        lo_we = 1'b0;
        model_hilo = 64'h0000_0000_FFFF_FFFF;
        check_output("acc_preload", {hi, lo}, model_hilo);
        apply_stimulus(32'd1, 32'd1, 1'b1);
        wait_done("acc_carry", 0);
        check_output("acc_carry_const", {hi, lo}, 64'h0000_0001_0000_0000);
        step();
`endif

        // Randomised requests interleaved with random IDLE writes
        for (int i = 0; i < 16; i++) begin
            ra = $urandom();
            rb = $urandom();
            rw = $urandom();
            if (i % 5 == 1) ra = 32'h8000_0000;
            if (i % 7 == 3) rb = 32'hFFFF_FFFF;
            if ($urandom_range(0, 2) == 0) begin
                hi_we = 1'($urandom_range(0, 1));
                lo_we = 1'($urandom_range(0, 1));
                wdata = rw;
                step();
                if (hi_we) model_hilo[63:32] = rw;
                if (lo_we) model_hilo[31:0]  = rw;
                hi_we = 1'b0;
                lo_we = 1'b0;
                check_output("rand_write", {hi, lo}, model_hilo);
            end
            rsel = 1'($urandom_range(0, 1));
            apply_stimulus(ra, rb, rsel);
            wait_done("rand_mul", 0);
            step();
            check_output("rand_done_clears", 64'(done), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
